// File: rtl/axis_packet_arbiter_pkg.sv
// Shared AXI-Stream types and constants for the packet arbiter slice.
package axis_packet_arbiter_pkg;

  localparam int unsigned CHANNEL_NUMBER       = 5;
  localparam int unsigned CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER);
  localparam int unsigned DATA_WIDTH           = 32;
  localparam int unsigned ID_WIDTH             = 4;
  localparam int unsigned DEST_WIDTH           = 4;
  localparam int unsigned USER_WIDTH           = 4;

  // TID value carried by the first beat of every routed packet
  localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = ID_WIDTH'(4'h1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } axis_data_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// N input AXI-Stream channels plus the merged output channel.
interface axis_packet_arbiter_if
  import axis_packet_arbiter_pkg::*;
();

  axis_data_t                in_data [CHANNEL_NUMBER];
  logic [CHANNEL_NUMBER-1:0] in_valid;
  logic [CHANNEL_NUMBER-1:0] in_ready;
  axis_data_t                out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/axis_packet_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_last_idx, wrapping modulo N.
module axis_packet_arbiter_rr_arbiter
  import axis_packet_arbiter_pkg::*;
(
  input  logic [CHANNEL_NUMBER-1:0]       i_req,
  input  logic [CHANNEL_NUMBER_WIDTH-1:0] i_last_idx,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] o_gnt_idx_c,
  output logic                            o_gnt_valid_c
);

  // Scan farthest-first so the nearest requester after i_last_idx overwrites last
  always_comb begin
    int unsigned               idx;
    logic [CHANNEL_NUMBER-1:0] w_rot;
    o_gnt_idx_c   = '0;
    o_gnt_valid_c = 1'b0;
    idx           = 0;
    w_rot         = '0;
    for (int k = CHANNEL_NUMBER; k >= 1; k--) begin
      idx   = (32'(i_last_idx) + 32'(k)) % CHANNEL_NUMBER;
      w_rot = i_req >> idx;
      if (w_rot[0]) begin
        o_gnt_valid_c = 1'b1;
        o_gnt_idx_c   = CHANNEL_NUMBER_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N:1 AXI-Stream packet merger: round-robin per packet, input locked until TLAST, 2-entry skid on output.
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  axis_packet_arbiter_if.slave            bus,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] o_grant_id,
  output logic                            o_busy,
  output logic                            o_protocol_err
);

  arb_state_t                      r_state;
  logic [CHANNEL_NUMBER_WIDTH-1:0] r_grant_id;
  logic [CHANNEL_NUMBER_WIDTH-1:0] r_last;
  logic                            r_busy;
  logic                            r_first;
  logic                            r_protocol_err;
  logic [CHANNEL_NUMBER-1:0]       r_in_ready;
  axis_data_t                      r_skid0;
  axis_data_t                      r_skid1;
  logic [1:0]                      r_occ;
  logic                            r_out_valid;

  logic [CHANNEL_NUMBER_WIDTH-1:0] w_gnt_idx;
  logic                            w_gnt_valid;
  axis_data_t                      w_beat;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_start;
  logic                            w_lock_nxt;
  logic [CHANNEL_NUMBER_WIDTH-1:0] w_grant_nxt;
  logic [CHANNEL_NUMBER-1:0]       w_in_ready_nxt;
  logic [1:0]                      w_occ_nxt;
  axis_data_t                      w_skid0_nxt;
  axis_data_t                      w_skid1_nxt;

  axis_packet_arbiter_rr_arbiter u_rr (
    .i_req         (bus.in_valid),
    .i_last_idx    (r_last),
    .o_gnt_idx_c   (w_gnt_idx),
    .o_gnt_valid_c (w_gnt_valid)
  );

  // in_ready is one-hot on the locked input, so any valid&ready is that input's beat
  assign w_beat  = bus.in_data[r_grant_id];
  assign w_push  = |(r_in_ready & bus.in_valid);
  assign w_pop   = r_out_valid & bus.out_ready;
  assign w_start = (r_state == ST_IDLE) & w_gnt_valid;

  always_comb begin
    w_lock_nxt     = w_start | ((r_state == ST_LOCK) & ~(w_push & w_beat.tlast));
    w_grant_nxt    = w_start ? w_gnt_idx : r_grant_id;
    w_in_ready_nxt = '0;
    w_occ_nxt      = r_occ;
    w_skid0_nxt    = r_skid0;
    w_skid1_nxt    = r_skid1;
    case (r_occ)
      2'd0: begin
        if (w_push) begin
          w_skid0_nxt = w_beat;
          w_occ_nxt   = 2'd1;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_skid0_nxt = w_beat;
        end else if (w_push) begin
          w_skid1_nxt = w_beat;
          w_occ_nxt   = 2'd2;
        end else if (w_pop) begin
          w_skid0_nxt = '0;
          w_occ_nxt   = 2'd0;
        end
      end
      default: begin
        if (w_pop) begin
          w_skid0_nxt = r_skid1;
          w_skid1_nxt = '0;
          w_occ_nxt   = 2'd1;
        end
      end
    endcase
    // Ready is registered from the next occupancy so no input->ready comb path exists
    if (w_lock_nxt && (w_occ_nxt != 2'd2)) begin
      w_in_ready_nxt = CHANNEL_NUMBER'(1) << w_grant_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_grant_id     <= '0;
      r_last         <= CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);
      r_busy         <= 1'b0;
      r_first        <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_protocol_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_state    <= ST_LOCK;
            r_grant_id <= w_gnt_idx;
            r_last     <= w_gnt_idx;
            r_busy     <= 1'b1;
            r_first    <= 1'b1;
          end
        end
        ST_LOCK: begin
          if (w_push) begin
            r_first        <= 1'b0;
            r_protocol_err <= r_first && (w_beat.tid != ROUTING_HEADER);
            if (w_beat.tlast) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid0     <= '0;
      r_skid1     <= '0;
      r_occ       <= 2'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= '0;
    end else begin
      r_skid0     <= w_skid0_nxt;
      r_skid1     <= w_skid1_nxt;
      r_occ       <= w_occ_nxt;
      r_out_valid <= (w_occ_nxt != 2'd0);
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_data   = r_skid0;
  assign bus.out_valid  = r_out_valid;
  assign o_grant_id     = r_grant_id;
  assign o_busy         = r_busy;
  assign o_protocol_err = r_protocol_err;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized scoreboard bench for axis_packet_arbiter with a queue-based round-robin packet model.
module tb_axis_packet_arbiter;
  import axis_packet_arbiter_pkg::*;

  localparam int NCH = CHANNEL_NUMBER;
  localparam logic [ID_WIDTH-1:0] TID_PAYLOAD = ID_WIDTH'(4'h2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CHANNEL_NUMBER_WIDTH-1:0] grant_id;
  logic busy;
  logic perr;

  axis_packet_arbiter_if bus();

  axis_packet_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .o_grant_id     (grant_id),
    .o_busy         (busy),
    .o_protocol_err (perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  axis_data_t exp_q[$];
  axis_data_t drv_q[NCH][$];
  int         seen_grants[$];
  int         m_last = NCH - 1;
  int         rmode = 0;
  bit         mon_en = 1'b0;
  bit         lat_arm = 1'b0;
  int         t_start = 0;
  int         busy_rises = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Output ready generator: always-on, 1,0,0,1 pattern, random, or held low
  logic [1:0] pk = 2'd0;
  logic [3:0] pat = 4'b1001;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pk = pk + 2'd1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = pat[pk];
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: output scoreboard, AXIS stability, per-handshake lock/protocol checks
  int         n_in = 0;
  int         n_out = 0;
  bit         exp_err = 1'b0;
  bit         exp_busy_low = 1'b0;
  bit [NCH-1:0] first_flag = '1;
  bit         prev_stall = 1'b0;
  axis_data_t prev_data = '0;
  bit         prev_busy = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      automatic int occ = n_in - n_out;
      automatic axis_data_t e;
      automatic axis_data_t b;
      chk("skid_occ_max", 64'(occ <= 2), 64'(1));
      if (occ == 2) chk("in_ready_full", 64'(bus.in_ready), 64'(0));
      chk("in_ready_onehot", 64'($countones(bus.in_ready) <= 1), 64'(1));
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_data", 64'(bus.out_data), 64'(prev_data));
      end
      if (bus.out_valid) begin
        if (lat_arm) begin
          chk("latency", 64'(cyc - t_start), 64'(2));
          lat_arm = 1'b0;
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 64'(bus.out_data), 64'(0) - 64'(1));
          else begin
            e = exp_q.pop_front();
            chk("out_beat", 64'(bus.out_data), 64'(e));
          end
          n_out++;
        end
      end else begin
        chk("out_zero_idle", 64'(bus.out_data), 64'(0));
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;

      chk("protocol_err", 64'(perr), 64'(exp_err));
      exp_err = 1'b0;
      if (exp_busy_low) begin
        chk("busy_after_tlast", 64'(busy), 64'(0));
        exp_busy_low = 1'b0;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if (bus.in_valid[ch] && bus.in_ready[ch]) begin
          b = bus.in_data[ch];
          chk("grant_id", 64'(grant_id), 64'(ch));
          chk("busy_in_packet", 64'(busy), 64'(1));
          if (first_flag[ch]) begin
            seen_grants.push_back(ch);
            exp_err = (b.tid != ROUTING_HEADER);
          end
          exp_busy_low   = b.tlast;
          first_flag[ch] = b.tlast;
          n_in++;
        end
      end
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
    end
  end

  // Present one channel's beats; first beats never gapped, later beats optionally gapped
  task automatic drive_ch(input int ch, input bit gaps);
    axis_data_t b;
    bit first = 1'b1;
    bit acc;
    int n;
    while (drv_q[ch].size() > 0) begin
      b = drv_q[ch].pop_front();
      if (!first && gaps) begin
        n = int'($urandom_range(0, 2));
        if (n > 0) begin
          bus.in_valid[ch] = 1'b0;
          repeat (n) begin @(posedge clk); #1; end
        end
      end
      bus.in_data[ch]  = b;
      bus.in_valid[ch] = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.in_ready[ch];
        @(posedge clk);
        #1;
        n++;
        if (!acc && n > 3000) begin
          chk("beat_accept_timeout", 64'(ch), 64'(NCH));
          drv_q[ch].delete();
          bus.in_valid[ch] = 1'b0;
          return;
        end
      end
      first = b.tlast;
    end
    bus.in_valid[ch] = 1'b0;
  endtask

  // Build packets, predict merged order with a round-robin packet queue model, drive and drain
  task automatic run_phase(input logic [NCH-1:0] mask, input int npk, input int minl, input int maxl,
                           input bit gaps, input int mode, input int badch);
    int pend [NCH];
    axis_data_t mdl [NCH][$];
    int egr[$];
    axis_data_t bt;
    int len, c, b0, k, nexp;
    seen_grants.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      pend[ch] = 0;
      if (mask[ch]) begin
        pend[ch] = npk;
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(32'(minl), 32'(maxl)));
          for (int i = 0; i < len; i++) begin
            bt.tdata = {8'(ch), 8'(p), 8'(i), 8'($urandom)};
            bt.tid   = (i != 0) ? TID_PAYLOAD : ((ch == badch && p == 0) ? TID_PAYLOAD : ROUTING_HEADER);
            bt.tdest = 4'($urandom);
            bt.tuser = 4'($urandom);
            bt.tlast = (i == len - 1);
            drv_q[ch].push_back(bt);
            mdl[ch].push_back(bt);
          end
        end
      end
    end
    nexp = 0;
    do begin
      c = -1;
      for (int s = 1; s <= NCH; s++)
        if (c < 0 && pend[(m_last + s) % NCH] > 0) c = (m_last + s) % NCH;
      if (c >= 0) begin
        pend[c]--;
        egr.push_back(c);
        m_last = c;
        nexp++;
        do begin
          bt = mdl[c].pop_front();
          exp_q.push_back(bt);
        end while (!bt.tlast);
      end
    end while (c >= 0);

    rmode = mode;
    b0 = busy_rises;
    @(posedge clk);
    #1;
    t_start = cyc;
    lat_arm = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        automatic int cc = ch;
        fork
          drive_ch(cc, gaps);
        join_none
      end
    end
    wait fork;
    k = 0;
    while (exp_q.size() > 0 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    chk("grant_count", 64'(seen_grants.size()), 64'(egr.size()));
    for (int i = 0; i < egr.size(); i++)
      if (i < seen_grants.size()) chk("grant_order", 64'(seen_grants[i]), 64'(egr[i]));
    chk("busy_pulses", 64'(busy_rises - b0), 64'(nexp));
  endtask

  initial begin
    axis_data_t hb;
    bus.in_valid = '0;
    for (int ch = 0; ch < NCH; ch++) bus.in_data[ch] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_protocol_err", 64'(perr), 64'(0));
    mon_en = 1'b1;

    run_phase(5'b00100, 1, 4, 4, 1'b0, 0, -1);
    run_phase(5'b01011, 2, 2, 2, 1'b0, 0, -1);
    run_phase(5'b00010, 1, 8, 8, 1'b0, 1, -1);
    run_phase(5'b10000, 1, 1, 1, 1'b0, 0, -1);
    run_phase(5'b00001, 1, 3, 3, 1'b0, 0, -1);
    run_phase(5'b00010, 1, 3, 3, 1'b0, 0, 1);
    for (int r = 0; r < 6; r++) begin
      automatic int bc = int'($urandom_range(0, 6));
      run_phase(5'($urandom_range(1, 31)), int'($urandom_range(1, 3)), 1, 6, 1'b1,
                int'($urandom_range(0, 2)), (bc >= NCH) ? -1 : bc);
    end

    // Asynchronous reset while a packet is stalled mid-transfer
    mon_en = 1'b0;
    rmode = 3;
    @(posedge clk);
    #1;
    hb = '0;
    hb.tid = ROUTING_HEADER;
    hb.tdata = 32'h5EED_0000;
    bus.in_data[0]  = hb;
    bus.in_valid[0] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before", 64'(busy), 64'(1));
    chk("mid_out_valid_before", 64'(bus.out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    bus.in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
